cpu_trace_recorder: RTL
=======================

# cpu_trace_recorder

Synthesizable per-cycle architectural trace recorder for the single-cycle CPU. It captures PC, instruction, register-file writes and data-memory writes on every retired cycle into a parametrised FIFO, which a host or bench drains through a valid/ready port. It generalises the cycle-by-cycle state dump into hardware, adding a configurable run length, a PC-match start trigger, a changes-only filter and overflow accounting. It sits beside the CPU and taps its internal write-back and memory-write signals.

## Interface
- DATA_W, 32, width of PC, instruction, write data and memory address
- DEPTH, 64, FIFO entries; power of two, minimum 2
- CNT_W, 16, width of the cycle index and drop counter
- CYCLE_LIMIT, 154, number of retired cycles to record per run; 0 means unlimited
- clk_i  in  1  clock
- rst_i  in  1  reset; one clock, synchronous, active-high
- valid_i  in  1  CPU retired an instruction this cycle
- pc_i, instr_i  in  DATA_W  PC and instruction of the retiring instruction
- rf_we_i  in  1, rf_waddr_i  in  5, rf_wdata_i  in  DATA_W  register-file write port
- dm_we_i  in  1, dm_addr_i  in  DATA_W, dm_wdata_i  in  DATA_W  data-memory write port
- arm_i  in  1  start a run (accepted in IDLE or DONE)
- clear_i  in  1  flush the FIFO
- mode_i  in  1  0 = record every cycle, 1 = record only state-changing cycles; sampled at arm
- trig_en_i  in  1, trig_pc_i  in  DATA_W  PC-match start trigger; sampled at arm
- trace_ready_i  in  1  consumer accepts the head entry
- trace_valid_o  out  1  FIFO is non-empty
- trace_data_o  out  CNT_W+5*DATA_W+7  head entry, packed MSB to LSB as {cyc, pc, instr, rf_we, dm_we, rf_waddr, rf_wdata, dm_addr, dm_wdata}
- state_o  out  2  0 IDLE, 1 WAIT_TRIG, 2 RECORD, 3 DONE
- done_o  out  1  high while in DONE
- overflow_o  out  1  sticky; set when a qualifying entry is dropped
- drop_cnt_o  out  CNT_W  number of dropped entries; saturates
- level_o  out  $clog2(DEPTH)+1  FIFO occupancy

## Operation
- Reset values: state IDLE; level_o, drop_cnt_o, overflow_o, done_o and trace_valid_o all 0; trace_data_o is 0 while the FIFO is empty.
- IDLE/DONE with arm_i: latch mode_i, trig_en_i and trig_pc_i; clear the cycle index, drop_cnt_o and overflow_o; FIFO contents are kept. Next state is WAIT_TRIG if trig_en_i, otherwise RECORD. arm_i in WAIT_TRIG or RECORD is ignored.
- WAIT_TRIG: when valid_i and pc_i==trig_pc_i, move to RECORD. The matching cycle is itself processed as a RECORD cycle with index 0.
- RECORD: every valid_i cycle is tagged with the current index, then the index increments. valid_i=0 cycles are neither counted nor recorded.
- Qualification:
  - mode 0: every valid cycle qualifies.
  - mode 1: a cycle qualifies only if (rf_we_i and rf_waddr_i!=0) or dm_we_i.
- Run end: when the cycle with index CYCLE_LIMIT-1 is processed, go to DONE on the same edge. The index wraps at 2^CNT_W only when CYCLE_LIMIT=0.
- Qualifying entry with FIFO full and no pop that cycle: the entry is dropped, overflow_o is set, and drop_cnt_o increments, saturating at all-ones.
- clear_i: empties the FIFO on the next edge and has priority over push and pop that cycle. State and counters are unaffected.
- Pop happens when trace_valid_o and trace_ready_i are both high. trace_ready_i while empty has no effect.

## Timing
- Push is on the clk_i edge that samples the qualifying cycle. The entry is visible on trace_valid_o and trace_data_o after that edge, so a write into an empty FIFO appears 1 cycle later.
- trace_data_o is first-word fall-through and holds the head entry stable until the pop edge.
- Simultaneous push and pop:
  - level unchanged.
  - when full, the push is accepted.
  - when empty, the new entry appears next cycle.
- level_o, overflow_o, drop_cnt_o and state_o are registered and update on the same edge as the event that changes them.
- rst_i mid-run returns to IDLE and empties the FIFO next edge, regardless of other inputs.
- Pointer wrap-around at DEPTH is seamless; level_o reaches DEPTH when full.

## Test plan
- Mode 0, CYCLE_LIMIT=154, arm with trig_en=0, valid_i every cycle -> exactly 154 entries with cyc 0..153 in order, DONE after the 154th, done_o=1; further valid_i records nothing.
- Mode 1, stream of 10 cycles where only cycles 2 (rf write to R8=5), 5 (rf write to R0) and 7 (dm write to addr 16, data 9) change state -> exactly 2 entries, cyc=2 and cyc=7, with correct flags and fields.
- trig_en=1, trig_pc=0x0000_0040, PCs counting 0,4,8,... -> state stays WAIT_TRIG for 16 cycles; the first entry has pc=0x40 and cyc=0.
- DEPTH=4, mode 0, trace_ready_i=0 for 10 valid cycles -> level_o=4, overflow_o=1, drop_cnt_o=6; the drained entries are cyc 0..3.
- Full FIFO with trace_ready_i=1 and a qualifying push in the same cycle -> level stays 4, the pushed entry is accepted, and drop_cnt_o is unchanged.
- clear_i and rst_i asserted mid-RECORD -> clear_i gives level 0 with state still RECORD; rst_i gives IDLE with all outputs back to their reset values.

Source files
------------

// File: rtl/cpu_trace_recorder_if.sv
// Trace drain port of the CPU trace recorder: FIFO head entry with valid/ready handshake.
interface cpu_trace_recorder_if #(
  parameter int unsigned ENTRY_W = 183
);
  logic               trace_valid_o;
  logic               trace_ready_i;
  logic [ENTRY_W-1:0] trace_data_o;

  modport master (output trace_valid_o, output trace_data_o, input trace_ready_i);
  modport slave  (input trace_valid_o, input trace_data_o, output trace_ready_i);
endinterface

// File: rtl/cpu_trace_recorder.sv
// Per-cycle architectural trace recorder: captures retired-cycle CPU state into a
// first-word fall-through FIFO with run length, PC trigger, change filter and drop accounting.
module cpu_trace_recorder #(
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned DEPTH       = 64,
  parameter int unsigned CNT_W       = 16,
  parameter int unsigned CYCLE_LIMIT = 154
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       valid_i,
  input  logic [DATA_W-1:0]          pc_i,
  input  logic [DATA_W-1:0]          instr_i,
  input  logic                       rf_we_i,
  input  logic [4:0]                 rf_waddr_i,
  input  logic [DATA_W-1:0]          rf_wdata_i,
  input  logic                       dm_we_i,
  input  logic [DATA_W-1:0]          dm_addr_i,
  input  logic [DATA_W-1:0]          dm_wdata_i,
  input  logic                       arm_i,
  input  logic                       clear_i,
  input  logic                       mode_i,
  input  logic                       trig_en_i,
  input  logic [DATA_W-1:0]          trig_pc_i,
  cpu_trace_recorder_if.master       trace,
  output logic [1:0]                 state_o,
  output logic                       done_o,
  output logic                       overflow_o,
  output logic [CNT_W-1:0]           drop_cnt_o,
  output logic [$clog2(DEPTH):0]     level_o
);
  localparam int unsigned AW      = $clog2(DEPTH);
  localparam int unsigned LW      = AW + 1;
  localparam int unsigned ENTRY_W = CNT_W + 5*DATA_W + 7;
  localparam logic [CNT_W-1:0] LAST_IDX = (CYCLE_LIMIT == 0) ? '0 : CNT_W'(CYCLE_LIMIT - 1);
  localparam logic [LW-1:0]    FULL_LVL = LW'(DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_TRIG = 2'd1,
    ST_RECORD    = 2'd2,
    ST_DONE      = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic               mode_q;
  logic [DATA_W-1:0]  trig_pc_q;
  logic [CNT_W-1:0]   cyc_q;
  logic [CNT_W-1:0]   drop_q;
  logic               ovf_q;

  logic [ENTRY_W-1:0] mem [DEPTH];
  logic [AW-1:0]      wptr_q, rptr_q;
  logic [LW-1:0]      level_q;

  logic               arm_ok, proc, last, qual;
  logic               full, empty, pop, push, drop;
  logic [ENTRY_W-1:0] entry;

  always_comb begin
    state_d = state_q;
    arm_ok  = 1'b0;
    proc    = 1'b0;
    last    = (CYCLE_LIMIT != 0) && (cyc_q == LAST_IDX);
    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (arm_i) begin
          arm_ok  = 1'b1;
          state_d = trig_en_i ? ST_WAIT_TRIG : ST_RECORD;
        end
      end
      // The trigger-matching cycle is itself recorded with index 0.
      ST_WAIT_TRIG: begin
        if (valid_i && (pc_i == trig_pc_q)) begin
          proc    = 1'b1;
          state_d = last ? ST_DONE : ST_RECORD;
        end
      end
      ST_RECORD: begin
        if (valid_i) begin
          proc = 1'b1;
          if (last) state_d = ST_DONE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    qual  = proc && (!mode_q || (rf_we_i && (rf_waddr_i != 5'd0)) || dm_we_i);
    full  = (level_q == FULL_LVL);
    empty = (level_q == '0);
    pop   = !empty && trace.trace_ready_i;
    push  = qual && (!full || pop);
    drop  = qual && full && !pop;
    entry = {cyc_q, pc_i, instr_i, rf_we_i, dm_we_i, rf_waddr_i, rf_wdata_i, dm_addr_i, dm_wdata_i};
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      mode_q    <= 1'b0;
      trig_pc_q <= '0;
      cyc_q     <= '0;
      drop_q    <= '0;
      ovf_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      if (arm_ok) begin
        mode_q    <= mode_i;
        trig_pc_q <= trig_pc_i;
        cyc_q     <= '0;
        drop_q    <= '0;
        ovf_q     <= 1'b0;
      end else begin
        if (proc) cyc_q <= cyc_q + CNT_W'(1);
        if (drop) begin
          ovf_q <= 1'b1;
          if (drop_q != '1) drop_q <= drop_q + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + AW'(1);
      if (pop)  rptr_q <= rptr_q + AW'(1);
      unique case ({push, pop})
        2'b10:   level_q <= level_q + LW'(1);
        2'b01:   level_q <= level_q - LW'(1);
        default: level_q <= level_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i && !clear_i && push) mem[wptr_q] <= entry;
  end

  assign trace.trace_valid_o = !empty;
  assign trace.trace_data_o  = empty ? '0 : mem[rptr_q];
  assign state_o    = state_q;
  assign done_o     = (state_q == ST_DONE);
  assign overflow_o = ovf_q;
  assign drop_cnt_o = drop_q;
  assign level_o    = level_q;
endmodule
